majority_sample_sequencer: RTL and testbench
============================================

// Module: majority_sample_sequencer
//
// PURPOSE
//   Sequences the 8-input MAJORITY voter (asserts when >=5 of 8 inputs are high) for oversampled bit recovery.
//   - Takes 8 samples of a pre-synchronised serial input, one per programmable sample period.
//   - Votes the 8 samples through an internal MAJORITY instance.
//   - Presents the voted bit and raw samples on a valid/ready output handshake.
//   - Sits between the input synchroniser and the downstream bit/frame assembler.
//
// PARAMETERS
//   DIV_WIDTH  8  width of the sample-period divider; sample period = div+1 clk cycles
//
// PORTS
//   clk          in   1          system clock; all logic on rising edge
//   reset        in   1          synchronous, active-high reset
//   din          in   1          serial input, already synchronised to clk
//   div          in   DIV_WIDTH  sample period minus one; captured on accepted start
//   start        in   1          request one 8-sample vote; accepted only when idle (see below)
//   busy         out  1          high from accepted start until output handshake completes
//   bit_out      out  1          voted bit = MAJORITY(samples_out)
//   samples_out  out  8          captured samples; bit 0 = last sample, bit 7 = first sample
//   bit_valid    out  1          bit_out/samples_out valid; held until bit_ready
//   bit_ready    in   1          downstream accepts the result when high with bit_valid
//   overrun      out  1          one-cycle pulse when start is asserted but not accepted
//
// BEHAVIOUR
//   - Reset: state IDLE; busy, bit_out, samples_out, bit_valid, overrun = 0; divider, sample count and shift register cleared.
//   - Reset mid-operation aborts the operation; no bit_valid is produced for it.
//   - FSM states: IDLE, SAMPLE, VOTE, HOLD.
//   - IDLE:
//     - start=1: capture div as D, clear divider counter, sample count and shift register; go to SAMPLE.
//     - busy=1 from the next cycle.
//   - SAMPLE:
//     - Divider counter increments each cycle from 0. Strobe when counter==D; on strobe the counter wraps to 0.
//     - On strobe: shift register <= {sreg[6:0], din}; sample count increments.
//     - After the 8th strobe, go to VOTE. D=0 samples every cycle.
//   - VOTE (exactly 1 cycle):
//     - Register bit_out <= MAJORITY(sreg) and samples_out <= sreg.
//     - Set bit_valid=1; go to HOLD.
//   - HOLD:
//     - bit_valid, bit_out and samples_out held stable until bit_valid & bit_ready.
//     - On handshake, bit_valid drops next cycle.
//     - Handshake with start=0: go to IDLE; busy drops next cycle.
//     - Handshake with start=1 in the same cycle: back-to-back restart. Go directly to SAMPLE, capture div, busy stays 1.
//   - Latency: start accepted at edge t -> bit_valid first high in cycle t + 8*(D+1) + 2.
//     - D=0 gives 10 cycles.
//   - Throughput: back-to-back operation gives one result per 8*(D+1)+2 cycles when bit_ready is held high.
//   - overrun: 1-cycle pulse in the cycle after start=1 is seen in SAMPLE, VOTE, or HOLD without a handshake.
//     - The start is dropped; the current operation is unaffected.
//   - div changes while busy are ignored until the next accepted start.
//   - bit_ready while bit_valid=0 is ignored.
//
// TESTING
//   1. div=0, din=1 constant, start pulse -> bit_valid high at cycle +10, bit_out=1, samples_out=8'hFF.
//   2. div=3, per-strobe din 1,1,0,1,0,1,1,0 (5 ones) -> samples_out=8'hD6, bit_out=1, bit_valid at cycle +34.
//   3. div=1, per-strobe din 1,0,0,1,1,0,0,1 (4 ones) -> samples_out=8'h99, bit_out=0.
//   4. bit_ready low 20 cycles after bit_valid, start pulsed during HOLD:
//      -> outputs stable throughout, overrun pulses once, no restart; bit_ready=1 -> IDLE, busy=0.
//   5. bit_ready=1 and start=1 in the same HOLD cycle:
//      -> busy stays 1, next bit_valid exactly 8*(D+1)+2 cycles after the handshake edge.
//   6. reset asserted after 4 strobes:
//      -> next cycle all outputs 0 and IDLE; next start collects a full fresh 8 samples (samples_out = new data only).

Source files
------------

// File: rtl/majority_sample_sequencer.sv
// -----------------------------------------------------------------------------
// majority_sample_sequencer
//   Oversampled bit recovery. On an accepted start, takes 8 samples of a
//   pre-synchronised serial input (one per div+1 clock periods), votes them
//   through an 8-input majority (>=5 of 8 high), and presents the voted bit
//   plus the raw samples on a valid/ready handshake.
//
// Ports
//   clk          in   1          system clock, rising edge
//   reset        in   1          synchronous, active-high reset
//   din          in   1          serial input, already synchronised to clk
//   div          in   DIV_WIDTH  sample period minus one, captured on accepted start
//   start        in   1          request one 8-sample vote (accepted when idle,
//                                or together with the output handshake)
//   busy         out  1          high from accepted start until handshake completes
//   bit_out      out  1          majority of samples_out
//   samples_out  out  8          captured samples, bit 7 = first, bit 0 = last
//   bit_valid    out  1          result valid, held until bit_ready
//   bit_ready    in   1          downstream accepts result
//   overrun      out  1          one-cycle pulse when a start is dropped
// -----------------------------------------------------------------------------
module majority_sample_sequencer #(
  parameter int unsigned DIV_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 din,
  input  logic [DIV_WIDTH-1:0] div,
  input  logic                 start,
  output logic                 busy,
  output logic                 bit_out,
  output logic [7:0]           samples_out,
  output logic                 bit_valid,
  input  logic                 bit_ready,
  output logic                 overrun
);

  localparam int unsigned NSAMP  = 8;
  localparam int unsigned SCNT_W = 3;
  localparam int unsigned ONES_W = 4;
  localparam int unsigned MAJ_TH = 5;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SAMPLE = 2'd1,
    S_VOTE   = 2'd2,
    S_HOLD   = 2'd3
  } state_t;

  state_t               r_state;
  logic [DIV_WIDTH-1:0] r_div;
  logic [DIV_WIDTH-1:0] r_divcnt;
  logic [SCNT_W-1:0]    r_scnt;
  logic [NSAMP-1:0]     r_sreg;
  logic                 r_busy;
  logic                 r_bit_out;
  logic [NSAMP-1:0]     r_samples;
  logic                 r_bit_valid;
  logic                 r_overrun;

  logic                 w_strobe;
  logic                 w_handshake;
  logic [ONES_W-1:0]    w_ones;
  logic                 w_vote;

  // Sample strobe: divider counter has reached the captured period
  assign w_strobe    = (r_divcnt == r_div);
  assign w_handshake = r_bit_valid & bit_ready;

  // 8-input majority voter on the shift register
  always_comb begin
    w_ones = '0;
    for (int i = 0; i < int'(NSAMP); i++) begin
      w_ones = w_ones + ONES_W'(r_sreg[i]);
    end
    w_vote = (w_ones >= ONES_W'(MAJ_TH));
  end

  // Sequencer FSM with registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_div       <= '0;
      r_divcnt    <= '0;
      r_scnt      <= '0;
      r_sreg      <= '0;
      r_busy      <= 1'b0;
      r_bit_out   <= 1'b0;
      r_samples   <= '0;
      r_bit_valid <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      r_overrun <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_div    <= div;
            r_divcnt <= '0;
            r_scnt   <= '0;
            r_sreg   <= '0;
            r_busy   <= 1'b1;
            r_state  <= S_SAMPLE;
          end
        end

        S_SAMPLE: begin
          if (start) begin
            r_overrun <= 1'b1;
          end
          if (w_strobe) begin
            r_divcnt <= '0;
            r_sreg   <= {r_sreg[NSAMP-2:0], din};
            r_scnt   <= r_scnt + SCNT_W'(1);
            if (r_scnt == SCNT_W'(NSAMP - 1)) begin
              r_state <= S_VOTE;
            end
          end else begin
            r_divcnt <= r_divcnt + DIV_WIDTH'(1);
          end
        end

        S_VOTE: begin
          if (start) begin
            r_overrun <= 1'b1;
          end
          r_bit_out   <= w_vote;
          r_samples   <= r_sreg;
          r_bit_valid <= 1'b1;
          r_state     <= S_HOLD;
        end

        S_HOLD: begin
          if (w_handshake) begin
            r_bit_valid <= 1'b0;
            if (start) begin
              // Back-to-back restart: busy stays high
              r_div    <= div;
              r_divcnt <= '0;
              r_scnt   <= '0;
              r_sreg   <= '0;
              r_state  <= S_SAMPLE;
            end else begin
              r_busy  <= 1'b0;
              r_state <= S_IDLE;
            end
          end else if (start) begin
            r_overrun <= 1'b1;
          end
        end

        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign busy        = r_busy;
  assign bit_out     = r_bit_out;
  assign samples_out = r_samples;
  assign bit_valid   = r_bit_valid;
  assign overrun     = r_overrun;

endmodule

// File: tb/tb_majority_sample_sequencer.sv
// -----------------------------------------------------------------------------
// tb_majority_sample_sequencer
//   Transaction-level reference model (accept edge + captured period, samples
//   taken from a din history at edges t0 + k*(D+1)) compared against the DUT
//   every cycle, plus directed scenarios with hand-computed expectations.
// -----------------------------------------------------------------------------
module tb_majority_sample_sequencer;

  localparam int unsigned DIV_WIDTH = 8;
  localparam int          HIST      = 16384;

  logic                 clk;
  logic                 reset;
  logic                 din;
  logic [DIV_WIDTH-1:0] div;
  logic                 start;
  logic                 busy;
  logic                 bit_out;
  logic [7:0]           samples_out;
  logic                 bit_valid;
  logic                 bit_ready;
  logic                 overrun;

  majority_sample_sequencer #(.DIV_WIDTH(DIV_WIDTH)) dut (
    .clk         (clk),
    .reset       (reset),
    .din         (din),
    .div         (div),
    .start       (start),
    .busy        (busy),
    .bit_out     (bit_out),
    .samples_out (samples_out),
    .bit_valid   (bit_valid),
    .bit_ready   (bit_ready),
    .overrun     (overrun)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;
  logic din_hist [0:HIST-1];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_tests++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  // ---------------- reference model + per-cycle compare ----------------
  bit         m_active = 1'b0;
  bit         m_valid  = 1'b0;
  int         m_t0     = 0;
  int         m_d      = 0;
  logic       e_busy   = 1'b0;
  logic       e_valid  = 1'b0;
  logic       e_ovr    = 1'b0;
  logic       e_bit    = 1'b0;
  logic [7:0] e_samp   = 8'h00;

  always @(posedge clk) begin
    cyc = cyc + 1;
    if (cyc < HIST) din_hist[cyc] = din;
    if (reset) begin
      m_active = 1'b0;
      m_valid  = 1'b0;
      e_ovr    = 1'b0;
      e_bit    = 1'b0;
      e_samp   = 8'h00;
    end else begin
      e_ovr = 1'b0;
      if (!m_active) begin
        if (start) begin
          m_active = 1'b1;
          m_t0     = cyc;
          m_d      = int'(div);
        end
      end else if (m_valid) begin
        if (bit_ready) begin
          m_valid = 1'b0;
          if (start) begin
            m_t0 = cyc;
            m_d  = int'(div);
          end else begin
            m_active = 1'b0;
          end
        end else if (start) begin
          e_ovr = 1'b1;
        end
      end else begin
        if (start) e_ovr = 1'b1;
        // Result appears one edge after the 8th sample edge
        if (cyc == m_t0 + 8 * (m_d + 1) + 1) begin
          m_valid = 1'b1;
          for (int k = 1; k <= 8; k++) begin
            e_samp[8-k] = din_hist[m_t0 + k * (m_d + 1)];
          end
          e_bit = ($countones(e_samp) >= 5);
        end
      end
    end
    e_busy  = m_active;
    e_valid = m_valid;
    #1;
    chk("busy",        32'(busy),        32'(e_busy));
    chk("bit_valid",   32'(bit_valid),   32'(e_valid));
    chk("overrun",     32'(overrun),     32'(e_ovr));
    chk("bit_out",     32'(bit_out),     32'(e_bit));
    chk("samples_out", 32'(samples_out), 32'(e_samp));
  end

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(negedge clk);
  endtask

  task automatic do_start(input int d, output int t);
    div   = DIV_WIDTH'(d);
    start = 1'b1;
    step();
    start = 1'b0;
    t     = cyc;
    div   = DIV_WIDTH'($urandom_range(0, 255));  // must be ignored while busy
  endtask

  // Drive pat[7] for the first strobe ... pat[0] for the last; random elsewhere
  task automatic run_pattern(input int d, input logic [7:0] pat);
    for (int k = 0; k < 8; k++) begin
      for (int j = 0; j <= d; j++) begin
        din = (j == d) ? pat[7-k] : 1'($urandom_range(0, 1));
        step();
      end
    end
  endtask

  // Latency = edge at which bit_valid is first sampled high, minus accept edge
  task automatic wait_valid(input string name, input int t, output int lat);
    bit ok;
    ok  = 1'b0;
    lat = -1;
    for (int i = 0; i < 600 && !ok; i++) begin
      if (bit_valid) begin
        ok  = 1'b1;
        lat = cyc + 1 - t;
      end else begin
        din = 1'($urandom_range(0, 1));
        step();
      end
    end
    if (!ok) chk({name, "_timeout"}, 32'(0), 32'(1));
  endtask

  task automatic handshake();
    bit_ready = 1'b1;
    step();
    bit_ready = 1'b0;
  endtask

  // ---------------- directed + random scenarios ----------------
  initial begin
    int t;
    int lat;
    int ovr_cnt;
    bit stable_busy;

    reset = 1'b1; din = 1'b0; div = '0; start = 1'b0; bit_ready = 1'b0;
    repeat (3) step();
    chk("rst_busy",    32'(busy),        32'(0));
    chk("rst_valid",   32'(bit_valid),   32'(0));
    chk("rst_samples", 32'(samples_out), 32'(0));
    reset = 1'b0;
    step();

    // 1: div=0, din=1
    din = 1'b1;
    do_start(0, t);
    run_pattern(0, 8'hFF);
    wait_valid("t1", t, lat);
    chk("t1_latency", 32'(lat),         32'(10));
    chk("t1_samples", 32'(samples_out), 32'(8'hFF));
    chk("t1_bit",     32'(bit_out),     32'(1));
    handshake();

    // 2: div=3, 5 ones
    do_start(3, t);
    run_pattern(3, 8'hD6);
    wait_valid("t2", t, lat);
    chk("t2_latency", 32'(lat),         32'(34));
    chk("t2_samples", 32'(samples_out), 32'(8'hD6));
    chk("t2_bit",     32'(bit_out),     32'(1));
    handshake();

    // 3: div=1, 4 ones
    do_start(1, t);
    run_pattern(1, 8'h99);
    wait_valid("t3", t, lat);
    chk("t3_latency", 32'(lat),         32'(18));
    chk("t3_samples", 32'(samples_out), 32'(8'h99));
    chk("t3_bit",     32'(bit_out),     32'(0));
    handshake();

    // 4: long HOLD with a dropped start
    do_start(0, t);
    run_pattern(0, 8'h00);
    wait_valid("t4", t, lat);
    ovr_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      start = (i == 5);
      step();
      start = 1'b0;
      if (overrun) ovr_cnt++;
      chk("t4_hold_valid",   32'(bit_valid),   32'(1));
      chk("t4_hold_samples", 32'(samples_out), 32'(8'h00));
    end
    chk("t4_overrun_count", 32'(ovr_cnt), 32'(1));
    chk("t4_busy_hold",     32'(busy),    32'(1));
    handshake();
    chk("t4_busy_after", 32'(busy), 32'(0));

    // 5: back-to-back restart at handshake
    do_start(2, t);
    run_pattern(2, 8'h0F);
    wait_valid("t5a", t, lat);
    div = DIV_WIDTH'(2); start = 1'b1; bit_ready = 1'b1;
    step();
    start = 1'b0; bit_ready = 1'b0;
    t = cyc;
    stable_busy = 1'b1;
    for (int k = 0; k < 8; k++) begin
      for (int j = 0; j <= 2; j++) begin
        din = 1'b1;
        if (!busy) stable_busy = 1'b0;
        step();
      end
    end
    chk("t5_busy_kept", 32'(stable_busy), 32'(1));
    wait_valid("t5b", t, lat);
    chk("t5_latency", 32'(lat),         32'(26));
    chk("t5_samples", 32'(samples_out), 32'(8'hFF));
    chk("t5_bit",     32'(bit_out),     32'(1));

    // 6: reset after 4 strobes, then a fresh run
    bit_ready = 1'b1; step(); bit_ready = 1'b0;
    do_start(1, t);
    for (int k = 0; k < 8; k++) begin
      din = 1'b1;
      step();
    end
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("t6_busy",    32'(busy),        32'(0));
    chk("t6_valid",   32'(bit_valid),   32'(0));
    chk("t6_bit",     32'(bit_out),     32'(0));
    chk("t6_samples", 32'(samples_out), 32'(0));
    chk("t6_overrun", 32'(overrun),     32'(0));
    do_start(0, t);
    run_pattern(0, 8'h55);
    wait_valid("t6", t, lat);
    chk("t6_latency",   32'(lat),         32'(10));
    chk("t6_samples_n", 32'(samples_out), 32'(8'h55));
    chk("t6_bit_n",     32'(bit_out),     32'(0));
    handshake();

    // Random traffic against the model
    for (int i = 0; i < 4000; i++) begin
      reset     = ($urandom_range(0, 299) == 0);
      start     = ($urandom_range(0, 3) == 0);
      bit_ready = 1'($urandom_range(0, 1));
      din       = 1'($urandom_range(0, 1));
      div       = DIV_WIDTH'($urandom_range(0, 4));
      step();
    end
    reset = 1'b0; start = 1'b0; bit_ready = 1'b0;
    repeat (4) step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
